// File: rtl/exe_forwarding_unit.sv
// EXE-stage operand bypass: captures ID source registers, selects MEM/WB results
// over register-file operands, and counts forwarding events (saturating).
module exe_forwarding_unit #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              forward_en,
  input  logic              freeze,
  input  logic              flush,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic              id_two_src,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              mem_wb_en,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_W-1:0]  wb_dest,
  input  logic              wb_wb_en,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [DATA_W-1:0] exe_val_rn,
  input  logic [DATA_W-1:0] exe_val_rm,
  input  logic              clr_count,
  output logic [1:0]        sel_src1,
  output logic [1:0]        sel_src2,
  output logic [DATA_W-1:0] fwd_val1,
  output logic [DATA_W-1:0] fwd_val2,
  output logic [CNT_W-1:0]  fwd_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_W-1:0] src1_q;
  logic [REG_W-1:0] src2_q;
  logic             two_src_q;
  logic             valid_q;
  logic             fwd_event;

  // ID/EXE copy of source registers; flush wins over freeze so a wrong-path op never survives a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1_q    <= '0;
      src2_q    <= '0;
      two_src_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      src1_q    <= '0;
      src2_q    <= '0;
      two_src_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (!freeze) begin
      src1_q    <= id_src1;
      src2_q    <= id_src2;
      two_src_q <= id_two_src;
      valid_q   <= id_valid;
    end
  end

  // Bypass select: MEM is the younger writer, so it beats WB
  always_comb begin
    sel_src1 = SEL_RF;
    sel_src2 = SEL_RF;
    if (forward_en && valid_q) begin
      if (mem_wb_en && (mem_dest == src1_q)) begin
        sel_src1 = SEL_MEM;
      end else if (wb_wb_en && (wb_dest == src1_q)) begin
        sel_src1 = SEL_WB;
      end
      if (two_src_q) begin
        if (mem_wb_en && (mem_dest == src2_q)) begin
          sel_src2 = SEL_MEM;
        end else if (wb_wb_en && (wb_dest == src2_q)) begin
          sel_src2 = SEL_WB;
        end
      end
    end
  end

  always_comb begin
    fwd_val1 = exe_val_rn;
    fwd_val2 = exe_val_rm;
    case (sel_src1)
      SEL_MEM: fwd_val1 = mem_result;
      SEL_WB:  fwd_val1 = wb_value;
      default: fwd_val1 = exe_val_rn;
    endcase
    case (sel_src2)
      SEL_MEM: fwd_val2 = mem_result;
      SEL_WB:  fwd_val2 = wb_value;
      default: fwd_val2 = exe_val_rm;
    endcase
  end

  assign fwd_event = valid_q && ((sel_src1 != SEL_RF) || (sel_src2 != SEL_RF));

  // One count per forwarding cycle regardless of how many operands bypassed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count <= '0;
    end else if (clr_count) begin
      fwd_count <= '0;
    end else if (!freeze && fwd_event && (fwd_count != CNT_MAX)) begin
      fwd_count <= fwd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exe_forwarding_unit.sv
// Bench for exe_forwarding_unit: directed vector table, hand-written stall/flush/
// saturation sequences and randomized traffic against a behavioural model.
module tb_exe_forwarding_unit;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst_n, forward_en, freeze, flush;
  logic [REG_W-1:0]  id_src1, id_src2, mem_dest, wb_dest;
  logic              id_two_src, id_valid, mem_wb_en, wb_wb_en, clr_count;
  logic [DATA_W-1:0] mem_result, wb_value, exe_val_rn, exe_val_rm;
  logic [1:0]        sel_src1, sel_src2;
  logic [DATA_W-1:0] fwd_val1, fwd_val2;
  logic [CNT_W-1:0]  fwd_count;

  int tests = 0;
  int fails = 0;

  // Model of the captured instruction and the event count
  logic [REG_W-1:0] m_src1, m_src2;
  logic             m_two, m_valid;
  int               m_cnt;

  exe_forwarding_unit #(.REG_W(REG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_result(mem_result),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_value(wb_value),
    .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .clr_count(clr_count),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .fwd_val1(fwd_val1), .fwd_val2(fwd_val2),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  s1, s2;
    logic        two, valid, fe;
    logic [3:0]  md;
    logic        me;
    logic [31:0] mr;
    logic [3:0]  wd;
    logic        we;
    logic [31:0] wv, rn, rm;
    logic [1:0]  e1, e2;
    logic [31:0] ev1, ev2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] msel(input logic [REG_W-1:0] src, input logic gate);
    if (!forward_en || !m_valid || !gate) return 2'd0;
    if (mem_wb_en && mem_dest == src) return 2'd1;
    if (wb_wb_en && wb_dest == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] mval(input logic [1:0] s, input logic [31:0] rf);
    if (s == 2'd1) return mem_result;
    if (s == 2'd2) return wb_value;
    return rf;
  endfunction

  // Check outputs against the model for the current inputs, then advance one edge
  task automatic cycle();
    logic [1:0] s1, s2;
    logic ev;
    logic [REG_W-1:0] n1, n2;
    logic nt, nv;
    int nc;
    #1;
    s1 = msel(m_src1, 1'b1);
    s2 = msel(m_src2, m_two);
    chk("model_sel_src1", 32'(sel_src1), 32'(s1));
    chk("model_sel_src2", 32'(sel_src2), 32'(s2));
    chk("model_fwd_val1", fwd_val1, mval(s1, exe_val_rn));
    chk("model_fwd_val2", fwd_val2, mval(s2, exe_val_rm));
    chk("model_fwd_count", 32'(fwd_count), 32'(m_cnt));
    ev = m_valid && (s1 != 2'd0 || s2 != 2'd0);
    n1 = m_src1; n2 = m_src2; nt = m_two; nv = m_valid; nc = m_cnt;
    if (flush) begin
      n1 = '0; n2 = '0; nt = 1'b0; nv = 1'b0;
    end else if (!freeze) begin
      n1 = id_src1; n2 = id_src2; nt = id_two_src; nv = id_valid;
    end
    if (clr_count) nc = 0;
    else if (!freeze && ev && m_cnt < CNT_MAX) nc = m_cnt + 1;
    @(posedge clk);
    #1;
    m_src1 = n1; m_src2 = n2; m_two = nt; m_valid = nv; m_cnt = nc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_src1 = '0; m_src2 = '0; m_two = 1'b0; m_valid = 1'b0; m_cnt = 0;
    chk("reset_sel_src1", 32'(sel_src1), 32'd0);
    chk("reset_sel_src2", 32'(sel_src2), 32'd0);
    chk("reset_fwd_val1", fwd_val1, 32'h11);
    chk("reset_fwd_val2", fwd_val2, 32'h22);
    chk("reset_fwd_count", 32'(fwd_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic quiet();
    freeze = 0; flush = 0; clr_count = 0; forward_en = 1;
    mem_wb_en = 0; wb_wb_en = 0;
  endtask

  vec_t vecs[9];

  initial begin
    rst_n = 1'b1; forward_en = 1; freeze = 0; flush = 0; clr_count = 0;
    id_src1 = 0; id_src2 = 0; id_two_src = 0; id_valid = 0;
    mem_dest = 0; mem_wb_en = 0; mem_result = 0;
    wb_dest = 0; wb_wb_en = 0; wb_value = 0;
    exe_val_rn = 32'h11; exe_val_rm = 32'h22;
    m_src1 = '0; m_src2 = '0; m_two = 0; m_valid = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    //        s1 s2 two v fe md me mr           wd we wv           rn           rm           e1 e2 ev1          ev2
    vecs[0] = '{3, 0, 0, 1, 1, 3, 1, 32'hAA,       1, 0, 32'hBB,       32'h11,       32'h22,       1, 0, 32'hAA,       32'h22};
    vecs[1] = '{5, 0, 0, 1, 1, 5, 1, 32'h1,        5, 1, 32'h2,        32'h11,       32'h22,       1, 0, 32'h1,        32'h22};
    vecs[2] = '{0, 7, 0, 1, 1, 1, 0, 32'h5,        7, 1, 32'h77,       32'h31,       32'h32,       0, 0, 32'h31,       32'h32};
    vecs[3] = '{0, 7, 1, 1, 1, 1, 0, 32'h5,        7, 1, 32'h77,       32'h31,       32'h32,       0, 2, 32'h31,       32'h77};
    vecs[4] = '{3, 0, 0, 1, 0, 3, 1, 32'hAA,       0, 1, 32'hBB,       32'h41,       32'h42,       0, 0, 32'h41,       32'h42};
    vecs[5] = '{4, 4, 1, 0, 1, 4, 1, 32'hAA,       4, 1, 32'hBB,       32'h51,       32'h52,       0, 0, 32'h51,       32'h52};
    vecs[6] = '{15, 15, 1, 1, 1, 15, 0, 32'hAA,    15, 1, 32'hF0F0F0F0, 32'h61,      32'h62,       2, 2, 32'hF0F0F0F0, 32'hF0F0F0F0};
    vecs[7] = '{2, 2, 1, 1, 1, 2, 1, 32'hDEADBEEF, 3, 1, 32'hBB,       32'h71,       32'h72,       1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8] = '{6, 9, 1, 1, 1, 9, 1, 32'h99,       6, 1, 32'h66,       32'h81,       32'h82,       2, 1, 32'h66,       32'h99};

    for (int i = 0; i < 9; i++) begin
      quiet();
      id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
      id_two_src = vecs[i].two; id_valid = vecs[i].valid;
      cycle();
      forward_en = vecs[i].fe;
      mem_dest = vecs[i].md; mem_wb_en = vecs[i].me; mem_result = vecs[i].mr;
      wb_dest = vecs[i].wd; wb_wb_en = vecs[i].we; wb_value = vecs[i].wv;
      exe_val_rn = vecs[i].rn; exe_val_rm = vecs[i].rm;
      #1;
      chk($sformatf("vec%0d_sel_src1", i), 32'(sel_src1), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_sel_src2", i), 32'(sel_src2), 32'(vecs[i].e2));
      chk($sformatf("vec%0d_fwd_val1", i), fwd_val1, vecs[i].ev1);
      chk($sformatf("vec%0d_fwd_val2", i), fwd_val2, vecs[i].ev2);
      cycle();
      if (i == 0) chk("count_after_first_fwd", 32'(fwd_count), 32'd1);
    end

    // Freeze holds the captured source and suppresses counting
    quiet();
    exe_val_rn = 32'h11; exe_val_rm = 32'h22;
    id_src1 = 3; id_two_src = 0; id_valid = 1;
    cycle();
    freeze = 1; id_src1 = 9; mem_dest = 3; mem_wb_en = 1; mem_result = 32'h55;
    cycle();
    #1;
    chk("freeze_src_still_3", 32'(sel_src1), 32'd1);
    chk("freeze_count_held", 32'(fwd_count), 32'(m_cnt));
    mem_dest = 9;
    #1;
    chk("freeze_src_not_9", 32'(sel_src1), 32'd0);
    mem_dest = 3;
    flush = 1;
    cycle();
    flush = 0;
    #1;
    chk("flush_beats_freeze_sel1", 32'(sel_src1), 32'd0);
    chk("flush_beats_freeze_val1", fwd_val1, 32'h11);

    // Reset during a stall, then a normal capture on the first edge
    do_reset();
    freeze = 0; id_src1 = 4; id_valid = 1;
    cycle();
    mem_dest = 4; mem_wb_en = 1; mem_result = 32'h44;
    #1;
    chk("capture_after_reset_sel1", 32'(sel_src1), 32'd1);
    chk("capture_after_reset_val1", fwd_val1, 32'h44);

    // Saturation and clear
    clr_count = 1; id_src1 = 3; mem_dest = 3; mem_wb_en = 1;
    cycle();
    clr_count = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("count_saturated", 32'(fwd_count), 32'hF);
    clr_count = 1;
    cycle();
    chk("count_cleared", 32'(fwd_count), 32'd0);
    clr_count = 0;

    // Randomized traffic with a narrow register range to provoke matches
    for (int i = 0; i < 2000; i++) begin
      forward_en = ($urandom_range(0, 9) != 0);
      freeze     = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      clr_count  = ($urandom_range(0, 29) == 0);
      id_src1    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      id_src2    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      id_two_src = 1'($urandom);
      id_valid   = ($urandom_range(0, 4) != 0);
      mem_dest   = 4'($urandom_range(0, 3));
      wb_dest    = 4'($urandom_range(0, 3));
      mem_wb_en  = 1'($urandom);
      wb_wb_en   = 1'($urandom);
      mem_result = $urandom;
      wb_value   = $urandom;
      exe_val_rn = $urandom;
      exe_val_rm = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exe_forwarding_unit.md
# EXE_forwarding_unit

Execute-stage consumer of the hazard protocol whose producer is the ID-stage hazard detection unit. The hazard unit stalls decode only when `forward_en` is low. When `forward_en` is high, this block resolves the same RAW dependencies by bypassing MEM/WB results into the ALU operands. It owns its own ID/EXE copy of the source register numbers, with freeze/flush control, and keeps a saturating count of forwarding events for performance inspection.

## Interface
- `REG_W`, 4, register-number width
- `DATA_W`, 32, operand/result width
- `CNT_W`, 16, forwarding-event counter width

- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `forward_en` in 1 — forwarding globally enabled
- `freeze` in 1 — hold captured source state (ID/EXE stall)
- `flush` in 1 — load bubble into captured source state (branch taken)
- `id_src1`, `id_src2` in REG_W — ID-stage source register numbers (Rn, Rm/Rd)
- `id_two_src` in 1 — ID instruction reads `id_src2`
- `id_valid` in 1 — ID slot holds a real instruction
- `mem_dest` in REG_W, `mem_wb_en` in 1, `mem_result` in DATA_W — MEM-stage writer
- `wb_dest` in REG_W, `wb_wb_en` in 1, `wb_value` in DATA_W — WB-stage writer
- `exe_val_rn`, `exe_val_rm` in DATA_W — register-file operands carried to EXE
- `clr_count` in 1 — synchronous clear of event counter
- `sel_src1`, `sel_src2` out 2 — 00 regfile, 01 MEM, 10 WB (11 never driven)
- `fwd_val1`, `fwd_val2` out DATA_W — operand after bypass mux
- `fwd_count` out CNT_W — saturating forwarding-event count

## Operation
- Captured state: `src1_q`, `src2_q`, `two_src_q`, `valid_q`.
- Per edge, priority order is `flush` > `freeze` > normal.
  - `flush`: all captured state cleared to 0.
  - `freeze`: captured state held.
  - Normal: captured state loads the `id_*` inputs.
- Flush beats freeze: the wrong-path instruction must not survive a stall.
- Selection logic is combinational from the captured state and the current MEM/WB inputs.
  - `sel_src1` and `sel_src2` are 00 if `forward_en` is 0 or `valid_q` is 0.
  - `sel_src1` = 01 if `mem_wb_en` and `mem_dest == src1_q`. Otherwise 10 if `wb_wb_en` and `wb_dest == src1_q`. Otherwise 00.
  - `sel_src2` uses the same rule on `src2_q`, additionally gated by `two_src_q`. It is 00 when `two_src_q` is 0.
  - MEM has priority over WB when both match, so the youngest value wins.
  - All 16 register numbers compare identically; R15 gets no special case.
- Muxes:
  - `fwd_val1` = `exe_val_rn` / `mem_result` / `wb_value` per `sel_src1`.
  - `fwd_val2` uses the same mapping from `exe_val_rm` per `sel_src2`.
- Counter:
  - `event` = `valid_q` & (`sel_src1` != 0 | `sel_src2` != 0).
  - On each edge where `!freeze` and `event`, `fwd_count` increments by 1.
  - `fwd_count` saturates at all-ones and never wraps.
  - A cycle with both operands forwarded counts once.
  - `clr_count` forces 0 and has priority over increment.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - Captured state = 0 and `fwd_count` = 0.
  - Consequently `sel_src1` = `sel_src2` = 00, and `fwd_val1` = `exe_val_rn`, `fwd_val2` = `exe_val_rm`.
- Capture latency: 1 cycle. An `id_src*` value presented before edge N is used for selection during cycle N+1.
- Selection/mux latency: 0 cycles (combinational) relative to MEM/WB inputs.
- `fwd_count` reflects an event 1 cycle after the cycle in which it occurred.
- Reset asserted mid-stall: all state clears immediately. After release, the first edge captures `id_*` normally unless `freeze`/`flush` is asserted.
- `forward_en` toggling affects selection in the same cycle. Captured state is unaffected.

## Test plan
- Reset: `rst_n`=0 with `exe_val_rn`=0x11 -> `sel_src1`=00, `fwd_val1`=0x11, `fwd_count`=0.
- MEM forward: capture `id_src1`=3, `id_valid`=1. Next cycle `mem_dest`=3, `mem_wb_en`=1, `mem_result`=0xAA -> `sel_src1`=01, `fwd_val1`=0xAA. The count becomes 1 on the following edge.
- MEM over WB priority: `src1_q`=5, with `mem_dest`=`wb_dest`=5, both enables 1, `mem_result`=1, `wb_value`=2 -> `sel_src1`=01, `fwd_val1`=1.
- Two-src gating: `src2_q`=7, `two_src_q`=0, `wb_dest`=7, `wb_wb_en`=1 -> `sel_src2`=00. Repeat with `two_src_q`=1 -> `sel_src2`=10, `fwd_val2`=`wb_value`.
- Freeze/flush:
  - Freeze with `id_src1` changing 3->9 -> `src1_q` stays 3, count does not increment.
  - Freeze+flush together -> `valid_q`=0, selects 00.
  - `forward_en`=0 with a matching MEM dest -> selects 00.
- Counter saturation: with `CNT_W`=4, 20 consecutive forwarding cycles -> `fwd_count`=0xF. Then `clr_count`=1 -> 0 on the next edge.
